// File: rtl/rv32i_types.sv
// rtl/rv32i_types.sv - shared RV32I pipeline types for hazard control
package rv32i_types;

    typedef enum logic [1:0] {
        MD_IDLE,
        MD_BUSY,
        MD_DONE
    } md_state_t;

    typedef struct packed {
        logic load_pc;
        logic load_if_id;
        logic load_id_ex;
        logic load_ex_mem;
        logic load_mem_wb;
        logic bubble_id_ex;
        logic bubble_ex_mem;
        logic flush_if_id;
    } stage_ctrl_t;

    localparam stage_ctrl_t CTRL_FROZEN = stage_ctrl_t'(8'b0000_0000);
    localparam stage_ctrl_t CTRL_RUN    = stage_ctrl_t'(8'b1111_1000);

endpackage

// File: rtl/load_use_detect.sv
// rtl/load_use_detect.sv - compares ID sources against a load destination in EX
module load_use_detect
    import rv32i_types::*;
(
    input  logic [4:0] id_rs1,
    input  logic [4:0] id_rs2,
    input  logic       id_uses_rs1,
    input  logic       id_uses_rs2,
    input  logic [4:0] ex_rd,
    input  logic       ex_is_load,
    input  logic       ex_load_regfile,
    output logic       load_use
);

    logic rs1_hit;
    logic rs2_hit;

    assign rs1_hit  = id_uses_rs1 && (id_rs1 == ex_rd);
    assign rs2_hit  = id_uses_rs2 && (id_rs2 == ex_rd);
    // x0 is hardwired, so a load targeting it never produces a hazard
    assign load_use = ex_is_load && ex_load_regfile && (ex_rd != 5'd0) && (rs1_hit || rs2_hit);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// rtl/pipeline_hazard_ctrl.sv - stall/flush sequencer and perf counters for the 5-stage pipeline
module pipeline_hazard_ctrl
    import rv32i_types::*;
#(
    parameter int CNT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [4:0]           id_rs1,
    input  logic [4:0]           id_rs2,
    input  logic                 id_uses_rs1,
    input  logic                 id_uses_rs2,
    input  logic [4:0]           ex_rd,
    input  logic                 ex_is_load,
    input  logic                 ex_load_regfile,
    input  logic                 branch_take,
    input  logic                 ex_is_muldiv,
    input  logic                 muldiv_done,
    input  logic                 imem_read,
    input  logic                 imem_resp,
    input  logic                 dmem_read,
    input  logic                 dmem_write,
    input  logic                 dmem_resp,
    output logic                 muldiv_start,
    output logic                 load_pc,
    output logic                 load_if_id,
    output logic                 load_id_ex,
    output logic                 load_ex_mem,
    output logic                 load_mem_wb,
    output logic                 bubble_id_ex,
    output logic                 bubble_ex_mem,
    output logic                 flush_if_id,
    output logic [CNT_WIDTH-1:0] stall_cnt,
    output logic [CNT_WIDTH-1:0] flush_cnt
);

    md_state_t   state_q;
    md_state_t   state_d;
    stage_ctrl_t ctrl;
    logic        mem_stall;
    logic        md_wait;
    logic        load_use;

    load_use_detect u_load_use_detect (
        .id_rs1          (id_rs1),
        .id_rs2          (id_rs2),
        .id_uses_rs1     (id_uses_rs1),
        .id_uses_rs2     (id_uses_rs2),
        .ex_rd           (ex_rd),
        .ex_is_load      (ex_is_load),
        .ex_load_regfile (ex_load_regfile),
        .load_use        (load_use)
    );

    assign mem_stall = (imem_read && !imem_resp) || ((dmem_read || dmem_write) && !dmem_resp);
    assign md_wait   = ((state_q == MD_IDLE) && ex_is_muldiv) || (state_q == MD_BUSY);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= MD_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        ctrl         = CTRL_FROZEN;
        muldiv_start = 1'b0;
        state_d      = state_q;
        if (!rst) begin
            state_d = MD_IDLE;
        end else if (mem_stall) begin
            // the unit keeps running while memory freezes the pipe, so its done pulse must not be lost
            if ((state_q == MD_BUSY) && muldiv_done) begin
                state_d = MD_DONE;
            end
        end else begin
            case (state_q)
                MD_IDLE: begin
                    if (ex_is_muldiv) begin
                        muldiv_start = 1'b1;
                        state_d      = MD_BUSY;
                    end
                end
                MD_BUSY: begin
                    if (muldiv_done) begin
                        state_d = MD_DONE;
                    end
                end
                MD_DONE: state_d = MD_IDLE;
                default: state_d = MD_IDLE;
            endcase

            if (md_wait) begin
                ctrl.load_ex_mem   = 1'b1;
                ctrl.bubble_ex_mem = 1'b1;
                ctrl.load_mem_wb   = 1'b1;
            end else if (branch_take) begin
                ctrl              = CTRL_RUN;
                ctrl.flush_if_id  = 1'b1;
                ctrl.bubble_id_ex = 1'b1;
            end else if (load_use) begin
                ctrl              = CTRL_RUN;
                ctrl.load_pc      = 1'b0;
                ctrl.load_if_id   = 1'b0;
                ctrl.bubble_id_ex = 1'b1;
            end else begin
                ctrl = CTRL_RUN;
            end
        end
    end

    assign load_pc       = ctrl.load_pc;
    assign load_if_id    = ctrl.load_if_id;
    assign load_id_ex    = ctrl.load_id_ex;
    assign load_ex_mem   = ctrl.load_ex_mem;
    assign load_mem_wb   = ctrl.load_mem_wb;
    assign bubble_id_ex  = ctrl.bubble_id_ex;
    assign bubble_ex_mem = ctrl.bubble_ex_mem;
    assign flush_if_id   = ctrl.flush_if_id;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (!ctrl.load_pc) begin
                stall_cnt <= stall_cnt + CNT_WIDTH'(1);
            end
            if (ctrl.flush_if_id) begin
                flush_cnt <= flush_cnt + CNT_WIDTH'(1);
            end
        end
    end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb/tb_pipeline_hazard_ctrl.sv - directed self-checking bench for pipeline_hazard_ctrl
module tb_pipeline_hazard_ctrl;

    logic        clk;
    logic        rst;
    logic [4:0]  id_rs1;
    logic [4:0]  id_rs2;
    logic        id_uses_rs1;
    logic        id_uses_rs2;
    logic [4:0]  ex_rd;
    logic        ex_is_load;
    logic        ex_load_regfile;
    logic        branch_take;
    logic        ex_is_muldiv;
    logic        muldiv_done;
    logic        imem_read;
    logic        imem_resp;
    logic        dmem_read;
    logic        dmem_write;
    logic        dmem_resp;
    logic        muldiv_start;
    logic        load_pc;
    logic        load_if_id;
    logic        load_id_ex;
    logic        load_ex_mem;
    logic        load_mem_wb;
    logic        bubble_id_ex;
    logic        bubble_ex_mem;
    logic        flush_if_id;
    logic [31:0] stall_cnt;
    logic [31:0] flush_cnt;

    int n_assert;
    int n_fail;
    int exp_stall;
    int exp_flush;

    // {load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb, bubble_id_ex, bubble_ex_mem, flush_if_id, muldiv_start}
    logic [8:0] ov;
    assign ov = {load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb,
                 bubble_id_ex, bubble_ex_mem, flush_if_id, muldiv_start};

    localparam logic [8:0] V_ZERO   = 9'b00000_000_0;
    localparam logic [8:0] V_RUN    = 9'b11111_000_0;
    localparam logic [8:0] V_LDUSE  = 9'b00111_100_0;
    localparam logic [8:0] V_BRANCH = 9'b11111_101_0;
    localparam logic [8:0] V_MDSTRT = 9'b00011_010_1;
    localparam logic [8:0] V_MDWAIT = 9'b00011_010_0;

    pipeline_hazard_ctrl #(.CNT_WIDTH(32)) dut (
        .clk             (clk),
        .rst             (rst),
        .id_rs1          (id_rs1),
        .id_rs2          (id_rs2),
        .id_uses_rs1     (id_uses_rs1),
        .id_uses_rs2     (id_uses_rs2),
        .ex_rd           (ex_rd),
        .ex_is_load      (ex_is_load),
        .ex_load_regfile (ex_load_regfile),
        .branch_take     (branch_take),
        .ex_is_muldiv    (ex_is_muldiv),
        .muldiv_done     (muldiv_done),
        .imem_read       (imem_read),
        .imem_resp       (imem_resp),
        .dmem_read       (dmem_read),
        .dmem_write      (dmem_write),
        .dmem_resp       (dmem_resp),
        .muldiv_start    (muldiv_start),
        .load_pc         (load_pc),
        .load_if_id      (load_if_id),
        .load_id_ex      (load_id_ex),
        .load_ex_mem     (load_ex_mem),
        .load_mem_wb     (load_mem_wb),
        .bubble_id_ex    (bubble_id_ex),
        .bubble_ex_mem   (bubble_ex_mem),
        .flush_if_id     (flush_if_id),
        .stall_cnt       (stall_cnt),
        .flush_cnt       (flush_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        id_rs1 = 5'd0; id_rs2 = 5'd0; id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b0;
        ex_rd = 5'd0; ex_is_load = 1'b0; ex_load_regfile = 1'b0;
        branch_take = 1'b0; ex_is_muldiv = 1'b0; muldiv_done = 1'b0;
        imem_read = 1'b0; imem_resp = 1'b0;
        dmem_read = 1'b0; dmem_write = 1'b0; dmem_resp = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_cnt(input string tag);
        chk({tag, "_stall_cnt"}, stall_cnt, exp_stall);
        chk({tag, "_flush_cnt"}, flush_cnt, exp_flush);
    endtask

    initial begin
        n_assert = 0; n_fail = 0; exp_stall = 0; exp_flush = 0;
        idle_inputs();
        rst = 1'b0;
        branch_take = 1'b1;
        ex_is_muldiv = 1'b1;
        @(posedge clk);
        #2;
        chk("reset_outputs", {23'd0, ov}, {23'd0, V_ZERO});
        chk_cnt("reset");
        idle_inputs();
        rst = 1'b1;
        #1;
        chk("idle_run", {23'd0, ov}, {23'd0, V_RUN});
        tick();
        chk_cnt("idle");

        // lw x5 in EX, add x6,x5,x7 in ID
        ex_is_load = 1'b1; ex_load_regfile = 1'b1; ex_rd = 5'd5;
        id_rs1 = 5'd5; id_rs2 = 5'd7; id_uses_rs1 = 1'b1; id_uses_rs2 = 1'b1;
        #1;
        chk("load_use_rs1", {23'd0, ov}, {23'd0, V_LDUSE});
        tick(); exp_stall++;
        chk_cnt("load_use_rs1");
        idle_inputs();
        #1;
        chk("after_load_use", {23'd0, ov}, {23'd0, V_RUN});
        tick();
        chk_cnt("after_load_use");

        ex_is_load = 1'b1; ex_load_regfile = 1'b1; ex_rd = 5'd3;
        id_rs1 = 5'd9; id_rs2 = 5'd3; id_uses_rs1 = 1'b1; id_uses_rs2 = 1'b1;
        #1;
        chk("load_use_rs2", {23'd0, ov}, {23'd0, V_LDUSE});
        id_uses_rs2 = 1'b0;
        #1;
        chk("rs2_not_used", {23'd0, ov}, {23'd0, V_RUN});
        ex_rd = 5'd0; id_rs1 = 5'd0; id_rs2 = 5'd0; id_uses_rs2 = 1'b1;
        #1;
        chk("rd_zero_no_stall", {23'd0, ov}, {23'd0, V_RUN});
        tick();
        chk_cnt("rd_zero");

        // taken branch while a load-use hazard is also present
        ex_rd = 5'd5; id_rs1 = 5'd5; branch_take = 1'b1;
        #1;
        chk("branch_over_load_use", {23'd0, ov}, {23'd0, V_BRANCH});
        tick(); exp_flush++;
        chk_cnt("branch");
        idle_inputs();

        // mul/div with done on the fourth busy cycle
        ex_is_muldiv = 1'b1;
        #1;
        chk("md_start", {23'd0, ov}, {23'd0, V_MDSTRT});
        tick(); exp_stall++;
        for (int i = 1; i <= 4; i++) begin
            if (i == 4) muldiv_done = 1'b1;
            #1;
            chk($sformatf("md_busy_%0d", i), {23'd0, ov}, {23'd0, V_MDWAIT});
            tick(); exp_stall++;
        end
        muldiv_done = 1'b0;
        #1;
        chk("md_done_no_restart", {23'd0, ov}, {23'd0, V_RUN});
        tick();
        chk_cnt("md");
        ex_is_muldiv = 1'b0;
        #1;
        chk("md_back_idle", {23'd0, ov}, {23'd0, V_RUN});
        tick();

        // D-cache miss holding a taken branch for three cycles
        dmem_read = 1'b1; dmem_resp = 1'b0; branch_take = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk($sformatf("mem_stall_branch_%0d", i), {23'd0, ov}, {23'd0, V_ZERO});
            tick(); exp_stall++;
        end
        dmem_resp = 1'b1;
        #1;
        chk("branch_after_stall", {23'd0, ov}, {23'd0, V_BRANCH});
        tick(); exp_flush++;
        idle_inputs();
        #1;
        chk("single_flush", {23'd0, ov}, {23'd0, V_RUN});
        chk_cnt("mem_stall_branch");

        // done pulse arrives during an I-cache miss
        ex_is_muldiv = 1'b1;
        #1;
        chk("md2_start", {23'd0, ov}, {23'd0, V_MDSTRT});
        tick(); exp_stall++;
        imem_read = 1'b1; muldiv_done = 1'b1;
        #1;
        chk("md2_done_in_stall", {23'd0, ov}, {23'd0, V_ZERO});
        tick(); exp_stall++;
        muldiv_done = 1'b0;
        #1;
        chk("md2_done_held", {23'd0, ov}, {23'd0, V_ZERO});
        tick(); exp_stall++;
        imem_read = 1'b0;
        #1;
        chk("md2_done_release", {23'd0, ov}, {23'd0, V_RUN});
        tick();
        chk_cnt("md2");
        ex_is_muldiv = 1'b0;
        tick();

        // asynchronous reset in the middle of MD_BUSY
        ex_is_muldiv = 1'b1;
        #1;
        chk("md3_start", {23'd0, ov}, {23'd0, V_MDSTRT});
        tick();
        #1;
        chk("md3_busy", {23'd0, ov}, {23'd0, V_MDWAIT});
        rst = 1'b0;
        #1;
        exp_stall = 0; exp_flush = 0;
        chk("async_reset_outputs", {23'd0, ov}, {23'd0, V_ZERO});
        chk_cnt("async_reset");
        tick();
        rst = 1'b1;
        #1;
        chk("restart_after_reset", {23'd0, ov}, {23'd0, V_MDSTRT});
        tick(); exp_stall++;
        #1;
        chk("busy_after_restart", {23'd0, ov}, {23'd0, V_MDWAIT});
        chk_cnt("post_reset");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
- Central stall/flush sequencer for the 5-stage RV32I pipeline; sits beside the IF/ID/EX/MEM/WB buffers and drives their load and bubble controls.
- Arbitrates cache-miss freezes, load-use stalls, EX-resolved branch/jump flushes and the start/done handshake of a multi-cycle mul/div unit attached to EX.
- Keeps stall and flush performance counters.

Parameters:
- CNT_WIDTH, 32, width of the performance counters.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-low reset
- id_rs1, id_rs2  in  5  source registers of the instruction in ID
- id_uses_rs1, id_uses_rs2  in  1  ID instruction reads rs1/rs2
- ex_rd  in  5  destination register of the instruction in EX
- ex_is_load  in  1  EX instruction is a load
- ex_load_regfile  in  1  EX instruction writes rd
- branch_take  in  1  EX resolves a taken branch, jal or jalr
- ex_is_muldiv  in  1  EX holds a mul/div op
- muldiv_done  in  1  mul/div result valid; one-cycle pulse
- imem_read, imem_resp  in  1  I-cache request / response
- dmem_read, dmem_write, dmem_resp  in  1  D-cache request from MEM / response
- muldiv_start  out  1  one-cycle start pulse to the mul/div unit
- load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb  out  1  buffer load enables
- bubble_id_ex, bubble_ex_mem  out  1  the loading buffer takes a NOP instead of upstream data
- flush_if_id  out  1  IF/ID loads a NOP
- stall_cnt, flush_cnt  out  CNT_WIDTH  performance counters

Behaviour:
- Reset (rst=0, asynchronous): FSM returns to MD_IDLE; both counters are 0; all load_* = 0; bubble_*, flush_if_id and muldiv_start are 0.
- FSM states: MD_IDLE, MD_BUSY, MD_DONE.
  - MD_IDLE → MD_BUSY when ex_is_muldiv=1 and there is no mem stall; muldiv_start=1 in that cycle only.
  - MD_BUSY → MD_DONE on muldiv_done.
  - MD_DONE → MD_IDLE after one cycle.
- mem_stall = (imem_read & ~imem_resp) | ((dmem_read|dmem_write) & ~dmem_resp).
- Priority, highest first. All outputs are combinational from state and inputs.
  1. mem_stall: all load_* = 0; no bubble, no flush; FSM holds; muldiv_start = 0.
  2. md_wait (MD_IDLE with ex_is_muldiv=1, or MD_BUSY):
     - load_pc, load_if_id, load_id_ex = 0.
     - load_ex_mem = 1 with bubble_ex_mem = 1; load_mem_wb = 1.
  3. branch_take (also the MD_DONE cycle if EX branches, which cannot occur for muldiv):
     - all loads = 1; flush_if_id = 1; bubble_id_ex = 1.
     - PC takes the target.
     - Overrides load-use, because the ID instruction is discarded.
  4. load_use = ex_is_load & ex_load_regfile & ex_rd!=0 & ((id_uses_rs1 & id_rs1==ex_rd) | (id_uses_rs2 & id_rs2==ex_rd)):
     - load_pc = 0, load_if_id = 0; load_id_ex = 1 with bubble_id_ex = 1.
     - load_ex_mem = 1, load_mem_wb = 1.
  5. Otherwise: all loads = 1; no bubbles.
- MD_DONE: EX advances normally (rule 5, or rule 3 if branch_take); no restart, even though ex_is_muldiv is still 1 this cycle.
- A branch held during mem_stall keeps branch_take asserted because EX is frozen; the flush happens in the first cycle after the stall clears, and exactly once.
- A muldiv_done pulse while mem_stall=1 in MD_BUSY is still taken: the state moves to MD_DONE, and MD_DONE then holds until the stall clears.
- stall_cnt increments in every cycle where load_pc=0 and rst=1.
- flush_cnt increments in every cycle where flush_if_id=1.
- Both counters wrap modulo 2^CNT_WIDTH.
- ex_rd=0 never triggers load-use.

Decomposition:
- rv32i_types gains md_state_t (MD_IDLE, MD_BUSY, MD_DONE) and a stage_ctrl_t struct bundling the load/bubble/flush bits.
- One sub-module: load_use_detect (combinational hazard compare), instantiated once.

Test Plan:
- Load-use: EX lw x5, ID add x6,x5,x7 → exactly one cycle of load_pc=0, load_if_id=0, bubble_id_ex=1; stall_cnt 0→1.
- Same as above with ex_rd=0 → no stall; stall_cnt stays 0.
- Branch: branch_take=1 with load-use also true → flush_if_id=1, bubble_id_ex=1, load_pc=1; flush_cnt=1; stall_cnt unchanged.
- Mul/div: ex_is_muldiv=1, muldiv_done after 4 cycles:
  - muldiv_start pulses once.
  - 5 cycles with load_id_ex=0 and bubble_ex_mem=1, then one MD_DONE cycle with all loads=1; no second start.
- Mem stall overlapping branch: dmem_read=1, dmem_resp=0 for 3 cycles with branch_take=1 → all loads=0 for 3 cycles, then a single flush; flush_cnt=1.
- Reset: rst dropped mid-MD_BUSY → outputs go to reset values immediately with no clock edge; counters=0; after release the FSM is in MD_IDLE and a new muldiv_start is issued if ex_is_muldiv=1.
